// File: rtl/probe_capture_core.sv
// probe_capture_core: circular-buffer logic analyser core with mask/value
// triggering, run-time pre-trigger depth and a same-clock register readout.
module probe_capture_core #(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              sample_en_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic [AW-1:0]     pretrig_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     p_q, p_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic              done_q, done_d;
  logic              prev_match_q, prev_match_d;
  logic [DATA_W-1:0] prev_probe_q, prev_probe_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              mem_we;
  logic              match;
  logic              trig;
  logic [AW-1:0]     post_len;
  logic [AW-1:0]     rd_phys;
  logic [DATA_W-1:0] mem [DEPTH];

  // Trigger qualification against the current probe and the previous enabled sample
  always_comb begin
    match = ((probe_i ^ trig_val_i) & trig_mask_i) == '0;
    trig  = 1'b0;
    case (trig_mode_i)
      2'd0:    trig = match;
      2'd1:    trig = match & ~prev_match_q;
      2'd2:    trig = ((probe_i ^ prev_probe_q) & trig_mask_i) != '0;
      default: trig = 1'b1;
    endcase
  end

  // Capture sequencing: next state, write pointer, counters and status
  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    trig_addr_d  = trig_addr_q;
    done_d       = done_q;
    mem_we       = 1'b0;
    prev_match_d = sample_en_i ? match : prev_match_q;
    prev_probe_d = sample_en_i ? probe_i : prev_probe_q;
    // Samples still owed after the trigger; >= 1 whenever POST is entered
    post_len     = LAST_IDX - p_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          state_d     = ST_PRE;
          // pretrig_i is AW bits wide, so it can never exceed DEPTH-1
          p_d         = pretrig_i;
          wp_d        = '0;
          cnt_d       = '0;
          done_d      = 1'b0;
          trig_addr_d = '0;
        end
      end
      ST_PRE: begin
        if (p_q == '0) begin
          state_d = ST_WAIT;
        end else if (sample_en_i) begin
          mem_we = 1'b1;
          wp_d   = wp_q + AW'(1);
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q + AW'(1) == p_q) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sample_en_i) begin
          mem_we = 1'b1;
          wp_d   = wp_q + AW'(1);
          if (trig) begin
            trig_addr_d = wp_q;
            cnt_d       = '0;
            if (p_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end
      ST_POST: begin
        if (sample_en_i) begin
          mem_we = 1'b1;
          wp_d   = wp_q + AW'(1);
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q + AW'(1) == post_len) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Readout: index 0 is the oldest sample, i.e. P samples before the trigger
  always_comb begin
    rd_phys    = trig_addr_q - p_q + rd_addr_i;
    rd_valid_d = rd_en_i;
    rd_data_d  = '0;
    if (rd_en_i && (state_q == ST_DONE)) rd_data_d = mem[rd_phys];
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wp_q         <= '0;
      cnt_q        <= '0;
      p_q          <= '0;
      trig_addr_q  <= '0;
      done_q       <= 1'b0;
      prev_match_q <= 1'b0;
      prev_probe_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      trig_addr_q  <= trig_addr_d;
      done_q       <= done_d;
      prev_match_q <= prev_match_d;
      prev_probe_q <= prev_probe_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Sample buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q] <= probe_i;
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;

endmodule
